// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - constants shared by the core, the static RAM and the dump reader
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] MAX_RUN = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, READ, CAPT, HOLD, FIN} dump_state_t;

  // Runs longer than the RAM would re-read words, so they are cut to one full pass.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > MAX_RUN) ? MAX_RUN : c;
  endfunction

endpackage

// File: rtl/out_hold_reg.sv
// rtl/out_hold_reg.sv - registered valid/ready output stage
// Payload is loaded in one cycle and held until the downstream accepts it.
module out_hold_reg #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_dump_reader.sv
// rtl/ram_dump_reader.sv - streams a contiguous run of data RAM words out over valid/ready
// Read-only: each word takes READ, CAPT, HOLD; the address wraps at the end of the RAM.
module ram_dump_reader
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic              load;
  logic [DATA_W:0]   payload;
  logic [DATA_W:0]   out_word;
  logic              handshake;

  assign handshake = out_valid & out_ready;
  assign payload   = {remaining == REM_ONE, ram_rdata};

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    load          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt     = READ;
            addr_nxt      = start_addr;
            remaining_nxt = clamp_count(count);
          end
        end
      end
      READ: state_nxt = CAPT;
      CAPT: begin
        load      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          remaining_nxt = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state_nxt = FIN;
          end else begin
            addr_nxt  = addr + ADDR_ONE;
            state_nxt = READ;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_cs    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      busy      <= state_nxt inside {READ, CAPT, HOLD};
      done      <= (state_nxt == FIN);
      ram_cs    <= state_nxt inside {READ, CAPT};
    end
  end

  assign ram_rd   = ram_cs;
  assign ram_we   = 1'b0;
  assign ram_addr = addr;

  out_hold_reg #(.W(DATA_W + 1)) u_out_hold_reg (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load),
    .load_data (payload),
    .ready     (out_ready),
    .data      (out_word),
    .valid     (out_valid)
  );

  assign out_data = out_word[DATA_W-1:0];
  assign out_last = out_word[DATA_W];

endmodule

// File: tb/tb_ram_dump_reader.sv
// tb/tb_ram_dump_reader.sv - scoreboard bench for ram_dump_reader with a behavioural RAM
module tb_ram_dump_reader;
  import cpu_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy, done, ram_cs, ram_rd, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata, out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;

  ram_dump_reader dut (
    .CLK(CLK), .RESET(RESET), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 CLK = ~CLK;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge CLK) if (ram_cs && ram_rd && !ram_we) ram_rdata <= mem[ram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DATA_W:0]   exp_q[$];
  int                addr_log[$];
  int                hs_in_run = 0;
  int                first_hs_cyc = 0, last_hs_cyc = 0, accept_cyc = 0, done_edge = 0;
  int                done_seen = 0;
  int                rmode = 0;
  int                stall_left = 0;
  logic              held_v = 1'b0;
  logic [DATA_W:0]   held;
  logic              prev_cs = 1'b0;

  // Monitor: scoreboard pops on every handshake, plus stall and RAM-access observations.
  always @(negedge CLK) begin
    if (RESET) begin
      held_v  = 1'b0;
      prev_cs = 1'b0;
    end else begin
      if (held_v && out_valid) chk("stall_stable", {out_last, out_data}, held);
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held   = {out_last, out_data};
        held_v = 1'b1;
        chk("no_ram_in_stall", ram_cs, 0);
      end
      if (ram_cs && !prev_cs) addr_log.push_back(int'(ram_addr));
      prev_cs = ram_cs;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
        end else begin
          chk("word", {out_last, out_data}, exp_q.pop_front());
        end
        if (hs_in_run == 0) first_hs_cyc = cyc + 1;
        hs_in_run++;
        last_hs_cyc = cyc + 1;
      end
      if (done) begin
        done_seen++;
        chk("busy_low_with_done", busy, 0);
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && hs_in_run == 1 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b0;
    endcase
  end

  task automatic issue(input int a, input int c);
    int n;
    @(negedge CLK);
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    count      = (ADDR_W+1)'(c);
    n = (c > DEPTH) ? DEPTH : c;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[(a + i) % DEPTH]});
    accept_cyc = cyc + 1;
    hs_in_run  = 0;
    addr_log.delete();
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) begin
        seen = 1;
        done_edge = cyc;
      end else begin
        @(negedge CLK);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
      exp_q.delete();
    end else begin
      chk("queue_drained", exp_q.size(), 0);
      @(negedge CLK);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 3);
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    RESET = 1'b0;

    rmode = 0;
    issue(2, 3);
    wait_done(100);
    chk("first_hs_latency", first_hs_cyc - accept_cyc, 3);
    chk("last_hs_latency", last_hs_cyc - accept_cyc, 9);
    chk("done_after_last_hs", done_edge - last_hs_cyc, 0);

    rmode = 2;
    stall_left = 5;
    issue(2, 3);
    wait_done(100);
    chk("stall_latency", last_hs_cyc - accept_cyc, 14);
    chk("stall_reads", addr_log.size(), 3);

    rmode = 0;
    issue(14, 4);
    wait_done(100);
    chk("wrap_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", addr_log[0], 14);
      chk("wrap_a1", addr_log[1], 15);
      chk("wrap_a2", addr_log[2], 0);
      chk("wrap_a3", addr_log[3], 1);
    end

    issue(5, 0);
    wait_done(20);
    chk("zero_done_latency", done_edge - accept_cyc, 0);
    chk("zero_no_ram", addr_log.size(), 0);

    issue(3, 20);
    wait_done(200);
    chk("clamp_reads", addr_log.size(), 16);

    begin
      int d0;
      d0 = done_seen;
      issue(0, 4);
      repeat (3) @(negedge CLK);
      start = 1'b1; start_addr = 4'd9; count = 5'd2;
      @(negedge CLK);
      start = 1'b0;
      wait_done(100);
      repeat (8) @(negedge CLK);
      chk("ignored_start_done", done_seen - d0, 1);
      chk("ignored_start_idle", busy, 0);
    end

    begin
      int d0;
      bit got_v = 0;
      rmode = 3;
      issue(0, 5);
      for (int i = 0; i < 20 && !got_v; i++) begin
        if (out_valid) got_v = 1; else @(negedge CLK);
      end
      chk("hold_reached", got_v, 1);
      d0 = done_seen;
      #2 RESET = 1'b1;
      #1;
      chk("async_valid_drop", out_valid, 0);
      chk("async_busy_drop", busy, 0);
      exp_q.delete();
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      chk("no_done_after_reset", done_seen - d0, 0);
      rmode = 1;
      issue(7, 6);
      wait_done(300);
      chk("post_reset_reads", addr_log.size(), 6);
    end

    for (int r = 0; r < 15; r++) begin
      int a, c, n;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      a = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, 31);
      n = (c > DEPTH) ? DEPTH : c;
      rmode = $urandom_range(0, 1);
      issue(a, c);
      if (c != 0 && $urandom_range(0, 1) == 1) begin
        start = 1'b1; start_addr = ADDR_W'($urandom); count = (ADDR_W+1)'($urandom_range(1, 31));
        @(negedge CLK);
        start = 1'b0;
      end
      wait_done(600);
      chk("rand_reads", addr_log.size(), n);
    end

    repeat (4) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
